hold_timer: RTL

Parametrised successor to the switch-weighted output holder. On a qualified write request it sums the weights of the selected inputs and holds `out` high for exactly that many tick periods. It then reports completion and waits for the write request to be released before it re-arms. It sits downstream of the shared clock divider (tick source) and the write-button debouncer. Beyond the previous holder it adds a generic selector count and weights, counter width, saturation, abort, a done pulse, remaining-count visibility and an optional retrigger (extend) mode.

---
 rtl/hold_timer_pkg.sv | 25 ++
 rtl/hold_weight_sum.sv | 26 ++
 rtl/hold_timer.sv | 97 +++++++++
 3 files changed

// File: rtl/hold_timer_pkg.sv
// Shared types and helpers for the weighted hold timer.
// Default weights: sel[0]=88, sel[1]=80, sel[2]=56, sel[3]=32.
package hold_timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        WAIT_REL = 2'd2
    } ht_state_t;

    localparam int unsigned DEF_NSEL = 4;
    localparam int unsigned DEF_CW   = 9;
    localparam logic [DEF_NSEL*DEF_CW-1:0] DEF_WEIGHTS = {9'd32, 9'd56, 9'd80, 9'd88};

    // Unsigned add saturated to cw bits (cw <= 32).
    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input int unsigned cw);
        logic [32:0] s;
        logic [32:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (33'd1 << cw) - 33'd1;
        return (s > mx) ? mx[31:0] : s[31:0];
    endfunction

endpackage

// File: rtl/hold_weight_sum.sv
// Masked weighted sum of the selector inputs, saturated to CW bits.
// The accumulator is widened by clog2(NSEL) bits so it cannot wrap before the clamp.
module hold_weight_sum import hold_timer_pkg::*; #(
    parameter int unsigned          NSEL    = DEF_NSEL,
    parameter int unsigned          CW      = DEF_CW,
    parameter logic [NSEL*CW-1:0]   WEIGHTS = DEF_WEIGHTS
) (
    input  logic [NSEL-1:0] sel,
    output logic [CW-1:0]   sum
);

    localparam int unsigned SW = CW + $clog2(NSEL);

    logic [SW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int i = 0; i < NSEL; i++) begin
            if (sel[i]) begin
                acc = acc + SW'(WEIGHTS[i*CW +: CW]);
            end
        end
        sum = (acc > SW'({CW{1'b1}})) ? {CW{1'b1}} : acc[CW-1:0];
    end

endmodule

// File: rtl/hold_timer.sv
// Holds out high for the weighted sum of the selected inputs, counted in tick periods,
// then pulses done and waits for the write request to drop before re-arming.
module hold_timer import hold_timer_pkg::*; #(
    parameter int unsigned          NSEL    = DEF_NSEL,
    parameter int unsigned          CW      = DEF_CW,
    parameter logic [NSEL*CW-1:0]   WEIGHTS = DEF_WEIGHTS,
    parameter int unsigned          RETRIG  = 0
) (
    input  logic            sysclk,
    input  logic            rst,
    input  logic            tick,
    input  logic            write,
    input  logic [NSEL-1:0] sel,
    input  logic            abort,
    output logic            out,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   remaining
);

    ht_state_t     state;
    logic          write_q;
    logic [CW-1:0] sum;
    logic [CW-1:0] ext_val;
    logic          extend;

    hold_weight_sum #(
        .NSEL    (NSEL),
        .CW      (CW),
        .WEIGHTS (WEIGHTS)
    ) u_sum (
        .sel (sel),
        .sum (sum)
    );

    // Extension folds this tick's decrement in: remaining + sum - 1 (remaining >= 1 in HOLD).
    assign ext_val = CW'(sat_add(32'(remaining) - 32'd1, 32'(sum), CW));
    assign extend  = (RETRIG != 0) && write && !write_q && (|sel) && (sum != '0);

    always_ff @(posedge sysclk) begin
        if (rst) begin
            state     <= IDLE;
            write_q   <= 1'b0;
            out       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            if (tick) begin
                write_q <= write;
            end
            if (state == HOLD && abort) begin
                out       <= 1'b0;
                busy      <= 1'b0;
                remaining <= '0;
                state     <= WAIT_REL;
            end else if (tick) begin
                unique case (state)
                    IDLE: begin
                        if (write && (|sel)) begin
                            if (sum != '0) begin
                                remaining <= sum;
                                out       <= 1'b1;
                                busy      <= 1'b1;
                                state     <= HOLD;
                            end else begin
                                done  <= 1'b1;
                                state <= WAIT_REL;
                            end
                        end
                    end
                    HOLD: begin
                        if (extend) begin
                            remaining <= ext_val;
                        end else if (remaining == CW'(1)) begin
                            out       <= 1'b0;
                            busy      <= 1'b0;
                            remaining <= '0;
                            done      <= 1'b1;
                            state     <= WAIT_REL;
                        end else begin
                            remaining <= remaining - CW'(1);
                        end
                    end
                    WAIT_REL: begin
                        if (!write) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
